host_tx_arbiter: RTL and testbench

HOST_TX_ARBITER -- requirements
Module: host_tx_arbiter

---
 rtl/host_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_host_tx_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/host_tx_arbiter.sv
// Round-robin merge of NUM_SRC byte streams into one host TX stream, with a
// MAX_PKT_LEN beat cap per grant. Define TX_ARB_HEADER_EN to emit an F0|owner header byte per grant.
module host_tx_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int MAX_PKT_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC*8-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]   s_axis_tvalid,
  input  logic [NUM_SRC-1:0]   s_axis_tlast,
  output logic [NUM_SRC-1:0]   s_axis_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 forced_release
);

  localparam int          IDX_W     = $clog2(NUM_SRC);
  localparam logic [15:0] LAST_BEAT = 16'(MAX_PKT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef TX_ARB_HEADER_EN
    S_HDR  = 2'd1,
`endif
    S_XFER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [15:0]        beat_cnt_q, beat_cnt_d;

  logic [7:0]         own_data;
  logic               own_valid;
  logic               own_last;
  logic [NUM_SRC-1:0] owner_onehot;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               end_of_grant;

  // Mux the current owner's stream onto local signals.
  always_comb begin
    own_data     = 8'h00;
    own_valid    = 1'b0;
    own_last     = 1'b0;
    owner_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_data        = s_axis_tdata[i*8 +: 8];
        own_valid       = s_axis_tvalid[i];
        own_last        = s_axis_tlast[i];
        owner_onehot[i] = 1'b1;
      end
    end
  end

  // Round-robin search starting one past the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!pick_found && s_axis_tvalid[j] &&
            j == (int'(last_owner_q) + k) % NUM_SRC) begin
          pick_found = 1'b1;
          pick_idx   = IDX_W'(j);
        end
      end
    end
  end

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned, which is what keeps this block from inferring latches.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    beat_cnt_d     = beat_cnt_q;
    m_axis_tdata   = 8'h00;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s_axis_tready  = '0;
    grant          = '0;
    forced_release = 1'b0;
    end_of_grant   = own_last || (beat_cnt_q == LAST_BEAT);

    // Outputs are gated by rst so an abandoned packet never shows a beat.
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            owner_d    = pick_idx;
            beat_cnt_d = 16'd0;
`ifdef TX_ARB_HEADER_EN
            state_d    = S_HDR;
`else
            state_d    = S_XFER;
`endif
          end
        end
`ifdef TX_ARB_HEADER_EN
        S_HDR: begin
          grant         = owner_onehot;
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = 8'hF0 | 8'(owner_q);
          if (m_axis_tready) state_d = S_XFER;
        end
`endif
        S_XFER: begin
          grant         = owner_onehot;
          m_axis_tdata  = own_data;
          m_axis_tvalid = own_valid;
          m_axis_tlast  = end_of_grant;
          s_axis_tready = owner_onehot & {NUM_SRC{m_axis_tready}};
          if (own_valid && m_axis_tready) begin
            if (end_of_grant) begin
              state_d        = S_IDLE;
              last_owner_d   = owner_q;
              forced_release = !own_last;
            end else begin
              beat_cnt_d = beat_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_SRC - 1);
      beat_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_host_tx_arbiter.sv
// Randomized bench for host_tx_arbiter: a packet-level model of owner, round-robin
// pointer and beat budget predicts every output each cycle.
module tb_host_tx_arbiter;

  localparam int NUM_SRC     = 3;
  localparam int MAX_PKT_LEN = 4;
  localparam int N_CYCLES    = 4000;
`ifdef TX_ARB_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_SRC*8-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]   s_axis_tvalid;
  logic [NUM_SRC-1:0]   s_axis_tlast;
  logic [NUM_SRC-1:0]   s_axis_tready;
  logic [7:0]           m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;
  logic [NUM_SRC-1:0]   grant;
  logic                 forced_release;

  always #5 clk = ~clk;

  host_tx_arbiter #(.NUM_SRC(NUM_SRC), .MAX_PKT_LEN(MAX_PKT_LEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .grant          (grant),
    .forced_release (forced_release)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Source byte generators: each source emits a numbered byte sequence cut
  // into packets of random length (some longer than MAX_PKT_LEN).
  int seq [NUM_SRC];
  int rem [NUM_SRC];

  // Reference model of the arbiter at packet level.
  int m_owner;   // -1 when nobody holds the grant
  int m_last;
  int m_beats;   // beats already delivered in the current grant
  bit m_hdr;

  task automatic model_reset();
    m_owner = -1;
    m_last  = NUM_SRC - 1;
    m_beats = 0;
    m_hdr   = 1'b0;
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NUM_SRC; i++) begin
      s_axis_tdata[i*8 +: 8] = 8'((i << 6) | (seq[i] & 63));
      s_axis_tlast[i]        = (rem[i] == 1);
      s_axis_tvalid[i]       = ($urandom_range(0, 99) < 70);
    end
  endtask

  initial begin
    logic [NUM_SRC-1:0] exp_ready, exp_grant;
    logic [7:0]         exp_data;
    logic               exp_valid, exp_last, exp_forced, at_max, beat, found;

    for (int i = 0; i < NUM_SRC; i++) begin
      seq[i] = 0;
      rem[i] = $urandom_range(1, 7);
    end
    rst           = 1'b1;
    m_axis_tready = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    model_reset();

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      rst           = (cyc < 3) || ($urandom_range(0, 299) == 0);
      m_axis_tready = ($urandom_range(0, 99) < 65);
      drive_sources();
      #3;

      exp_valid  = 1'b0;
      exp_data   = 8'h00;
      exp_last   = 1'b0;
      exp_ready  = '0;
      exp_grant  = '0;
      exp_forced = 1'b0;
      at_max     = 1'b0;
      if (!rst && m_owner >= 0) begin
        exp_grant[m_owner] = 1'b1;
        if (m_hdr) begin
          exp_valid = 1'b1;
          exp_data  = 8'hF0 | 8'(m_owner);
        end else begin
          at_max             = (m_beats == MAX_PKT_LEN - 1);
          exp_valid          = s_axis_tvalid[m_owner];
          exp_data           = s_axis_tdata[m_owner*8 +: 8];
          exp_last           = s_axis_tlast[m_owner] || at_max;
          exp_ready[m_owner] = m_axis_tready;
          exp_forced         = exp_valid && m_axis_tready && at_max && !s_axis_tlast[m_owner];
        end
      end

      check("grant",          32'(grant),          32'(exp_grant));
      check("m_tvalid",       32'(m_axis_tvalid),  32'(exp_valid));
      check("m_tlast",        32'(m_axis_tlast),   32'(exp_last));
      check("s_tready",       32'(s_axis_tready),  32'(exp_ready));
      check("forced_release", 32'(forced_release), 32'(exp_forced));
      if (exp_valid) check("m_tdata", 32'(m_axis_tdata), 32'(exp_data));

      beat = exp_valid && m_axis_tready;
      if (rst) begin
        model_reset();
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (s_axis_tvalid[i] && exp_ready[i]) begin
            seq[i]++;
            if (rem[i] == 1) rem[i] = $urandom_range(1, 7);
            else rem[i]--;
          end
        end
        if (m_owner < 0) begin
          found = 1'b0;
          for (int k = 1; k <= NUM_SRC; k++) begin
            if (!found && s_axis_tvalid[(m_last + k) % NUM_SRC]) begin
              found   = 1'b1;
              m_owner = (m_last + k) % NUM_SRC;
              m_beats = 0;
              m_hdr   = HDR_EN;
            end
          end
        end else if (m_hdr) begin
          if (m_axis_tready) m_hdr = 1'b0;
        end else if (beat) begin
          if (exp_last) begin
            m_last  = m_owner;
            m_owner = -1;
          end else begin
            m_beats++;
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
